// File: rtl/row_dispatch_scheduler.sv
// Dynamic row dispatcher: hands row indices to whichever row engine is idle,
// counts write-backs and flags done once every row of the job has completed.
module row_dispatch_scheduler #(
  parameter int NUM_ROWS    = 8,
  parameter int NUM_WORKERS = 2,
  parameter int ROW_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_WORKERS-1:0]       worker_done,
  output logic [NUM_WORKERS-1:0]       worker_start,
  output logic [NUM_WORKERS*ROW_W-1:0] worker_row,
  output logic                         busy,
  output logic                         done,
  output logic [ROW_W:0]               rows_done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ROW_W:0] ROWS_MAX = (ROW_W+1)'(NUM_ROWS);
  localparam logic [ROW_W:0] ONE      = (ROW_W+1)'(1);

  state_t                       state, state_next;
  logic [ROW_W:0]               next_row, next_row_nxt, row_base;
  logic [NUM_WORKERS-1:0]       engine_busy, engine_busy_nxt;
  logic [NUM_WORKERS-1:0]       valid_done, avail, grant;
  logic [NUM_WORKERS-1:0]       worker_start_nxt;
  logic [NUM_WORKERS*ROW_W-1:0] worker_row_nxt;
  logic [ROW_W:0]               done_count, rows_done_nxt;
  logic                         dispatch, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      next_row     <= '0;
      engine_busy  <= '0;
      worker_start <= '0;
      worker_row   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rows_done    <= '0;
    end else begin
      state        <= state_next;
      next_row     <= next_row_nxt;
      engine_busy  <= engine_busy_nxt;
      worker_start <= worker_start_nxt;
      worker_row   <= worker_row_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      rows_done    <= rows_done_nxt;
    end
  end

  always_comb begin
    state_next       = state;
    next_row_nxt     = next_row;
    engine_busy_nxt  = engine_busy;
    worker_start_nxt = '0;
    worker_row_nxt   = worker_row;
    busy_nxt         = busy;
    done_nxt         = done;
    rows_done_nxt    = rows_done;
    valid_done       = '0;
    avail            = '0;
    grant            = '0;
    done_count       = '0;
    dispatch         = 1'b0;
    row_base         = next_row;

    case (state)
      IDLE: begin
        // Row 0 is dispatched on the accepting edge so the first engine starts one cycle after start.
        if (start) begin
          busy_nxt        = 1'b1;
          done_nxt        = 1'b0;
          rows_done_nxt   = '0;
          engine_busy_nxt = '0;
          row_base        = '0;
          avail           = '1;
          dispatch        = 1'b1;
          state_next      = RUN;
        end
      end
      RUN: begin
        valid_done = worker_done & engine_busy;
        for (int i = 0; i < NUM_WORKERS; i++)
          done_count = done_count + {{ROW_W{1'b0}}, valid_done[i]};
        rows_done_nxt   = rows_done + done_count;
        engine_busy_nxt = engine_busy & ~valid_done;
        // Availability uses the pre-completion busy mask: a freed engine waits one cycle.
        avail           = ~engine_busy;
        dispatch        = (next_row < ROWS_MAX);
        if (rows_done == ROWS_MAX)
          state_next = FINISH;
      end
      FINISH: begin
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    for (int i = 0; i < NUM_WORKERS; i++)
      if (dispatch && avail[i] && (grant == '0))
        grant[i] = 1'b1;

    if (grant != '0) begin
      worker_start_nxt = grant;
      engine_busy_nxt  = engine_busy_nxt | grant;
      next_row_nxt     = row_base + ONE;
      for (int i = 0; i < NUM_WORKERS; i++)
        if (grant[i])
          worker_row_nxt[i*ROW_W +: ROW_W] = row_base[ROW_W-1:0];
    end
  end

endmodule

// File: tb/tb_row_dispatch_scheduler.sv
// Bench for row_dispatch_scheduler: cycle vector table, corner sequences and a
// scoreboard-checked full job with latency-modelled row engines.
module tb_row_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] worker_done = 2'b00;
  logic [1:0] worker_start;
  logic [7:0] worker_row;
  logic       busy;
  logic       done;
  logic [4:0] rows_done;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic [1:0] wd;
    logic [1:0] ws;
    logic [7:0] wr;
    logic       bz;
    logic       dn;
    logic [4:0] rd;
  } vec_t;

  vec_t vecs[15];
  logic [3:0] sb[$];
  int cnt[2];
  int dispatched;

  row_dispatch_scheduler #(.NUM_ROWS(8), .NUM_WORKERS(2), .ROW_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .worker_done(worker_done),
    .worker_start(worker_start), .worker_row(worker_row),
    .busy(busy), .done(done), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [1:0] wd);
    @(negedge clk);
    reset = r;
    start = s;
    worker_done = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pop an expected row for every dispatch seen and arm that engine's completion timer.
  task automatic observe();
    for (int i = 0; i < 2; i++) begin
      if (worker_start[i]) begin
        checkOutput("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0)
          checkOutput("sb_row", {28'd0, worker_row[i*4 +: 4]}, {28'd0, sb.pop_front()});
        cnt[i] = 5;
        dispatched++;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 2'b01, 8'h00, 1'b1, 1'b0, 5'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 2'b10, 8'h10, 1'b1, 1'b0, 5'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 2'b00, 8'h10, 1'b1, 1'b0, 5'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 2'b00, 8'h10, 1'b1, 1'b0, 5'd1};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b01, 8'h12, 1'b1, 1'b0, 5'd1};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 2'b00, 8'h12, 1'b1, 1'b0, 5'd2};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b10, 8'h32, 1'b1, 1'b0, 5'd2};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 2'b00, 8'h32, 1'b1, 1'b0, 5'd4};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 2'b01, 8'h34, 1'b1, 1'b0, 5'd4};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 2'b10, 8'h54, 1'b1, 1'b0, 5'd4};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[14] = '{1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0};

    $display("[TB] vector table");
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].st, vecs[v].wd);
      checkOutput($sformatf("v%0d_worker_start", v), {30'd0, worker_start}, {30'd0, vecs[v].ws});
      checkOutput($sformatf("v%0d_worker_row", v), {24'd0, worker_row}, {24'd0, vecs[v].wr});
      checkOutput($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].bz});
      checkOutput($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].dn});
      checkOutput($sformatf("v%0d_rows_done", v), {27'd0, rows_done}, {27'd0, vecs[v].rd});
    end

    $display("[TB] engine1 finishes first");
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("ooo_start0", {30'd0, worker_start}, 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("ooo_start1", {30'd0, worker_start}, 32'h2);
    applyStimulus(1'b0, 1'b0, 2'b10);
    checkOutput("ooo_no_same_cycle", {30'd0, worker_start}, 32'h0);
    checkOutput("ooo_rows_done", {27'd0, rows_done}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("ooo_redispatch", {30'd0, worker_start}, 32'h2);
    checkOutput("ooo_row2_eng1", {28'd0, worker_row[7:4]}, 32'd2);

    $display("[TB] full job with 5-cycle engines");
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    cnt[0] = 0;
    cnt[1] = 0;
    dispatched = 0;
    for (int r = 0; r < 8; r++) sb.push_back(4'(r));
    applyStimulus(1'b0, 1'b1, 2'b00);
    observe();
    begin
      int budget = 200;
      while (!done && budget > 0) begin
        logic [1:0] wd;
        wd = 2'b00;
        for (int i = 0; i < 2; i++) begin
          if (cnt[i] == 1) wd[i] = 1'b1;
          if (cnt[i] > 0) cnt[i]--;
        end
        applyStimulus(1'b0, 1'b0, wd);
        observe();
        budget--;
      end
      checkOutput("job_finished_in_budget", {31'd0, done}, 32'd1);
    end
    checkOutput("job_rows_done", {27'd0, rows_done}, 32'd8);
    checkOutput("job_busy", {31'd0, busy}, 32'd0);
    checkOutput("job_dispatched", dispatched, 32'd8);
    checkOutput("job_sb_left", sb.size(), 32'd0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 2'b01);
      checkOutput("idle_done_held", {31'd0, done}, 32'd1);
      checkOutput("idle_rows_done_held", {27'd0, rows_done}, 32'd8);
      checkOutput("idle_no_start", {30'd0, worker_start}, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("restart_done", {31'd0, done}, 32'd0);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    checkOutput("restart_rows_done", {27'd0, rows_done}, 32'd0);
    checkOutput("restart_start", {30'd0, worker_start}, 32'h1);
    checkOutput("restart_row0", {28'd0, worker_row[3:0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
